// File: rtl/adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// Holds the default operand width.
package adder_pkg;

   localparam int ADDER_W_DEFAULT = 8;

endpackage

// File: rtl/adder_full_nbit_full_adder.sv
// One-bit full-adder cell used as a link in the ripple chain.
// Ports: a, b, cin -> s (sum bit), cout (majority carry).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_full_nbit.sv
// n-bit ripple-carry adder with registered sum and carry-out.
// Ports: clk, rst (sync, high), X, Y, Cin -> sum, carry.
module adder_full_nbit
   import adder_pkg::*;
#(
   parameter int n = ADDER_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] X,
   input  logic [n-1:0] Y,
   input  logic         Cin,
   output logic [n-1:0] sum,
   output logic         carry
);

   logic [n-1:0] w_s;
   logic [n-1:0] w_c;

   genvar j;
   generate
      for (j = 0; j < n; j++) begin : g_fa
         if (j == 0) begin : g_first
            full_adder u_fa (
               .a    (X[j]),
               .b    (Y[j]),
               .cin  (Cin),
               .s    (w_s[j]),
               .cout (w_c[j])
            );
         end else begin : g_rest
            full_adder u_fa (
               .a    (X[j]),
               .b    (Y[j]),
               .cin  (w_c[j-1]),
               .s    (w_s[j]),
               .cout (w_c[j])
            );
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sum   <= '0;
         carry <= 1'b0;
      end else begin
         sum   <= w_s;
         carry <= w_c[n-1];
      end
   end

endmodule

// File: tb/tb_adder_full_nbit.sv
// Directed and random bench for adder_full_nbit.
// Drives n=8, n=1 and n=16 instances; checks one cycle later.
module tb_adder_full_nbit;

   logic        clk;
   logic        rst;
   logic [7:0]  x8, y8, s8;
   logic        ci8, c8;
   logic [0:0]  x1, y1, s1;
   logic        ci1, c1;
   logic [15:0] x16, y16, s16;
   logic        ci16, c16;

   int checks = 0;
   int errors = 0;

   adder_full_nbit #(.n(8)) u_dut8 (
      .clk(clk), .rst(rst), .X(x8), .Y(y8), .Cin(ci8),
      .sum(s8), .carry(c8)
   );

   adder_full_nbit #(.n(1)) u_dut1 (
      .clk(clk), .rst(rst), .X(x1), .Y(y1), .Cin(ci1),
      .sum(s1), .carry(c1)
   );

   adder_full_nbit #(.n(16)) u_dut16 (
      .clk(clk), .rst(rst), .X(x16), .Y(y16), .Cin(ci16),
      .sum(s16), .carry(c16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [16:0] obs,
                      input logic [16:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // stage-0 patterns 001..110 as {Cin,X0,Y0}
   logic [7:0] exp0 [6] = '{8'h01, 8'h01, 8'h02, 8'h01, 8'h02, 8'h02};

   initial begin
      logic [2:0]  p;
      logic [16:0] e;
      int          cnt;

      rst = 1'b1;
      x8 = '0; y8 = '0; ci8 = 1'b0;
      x1 = '0; y1 = '0; ci1 = 1'b0;
      x16 = '0; y16 = '0; ci16 = 1'b0;

      // reset for two cycles
      for (int k = 0; k < 2; k++) begin
         tick();
         chk($sformatf("rst8_%0d", k), {8'h0, c8, s8}, 17'h0);
         chk($sformatf("rst1_%0d", k), {15'h0, c1, s1}, 17'h0);
         chk($sformatf("rst16_%0d", k), {c16, s16}, 17'h0);
      end
      rst = 1'b0;
      tick();
      chk("zero8", {8'h0, c8, s8}, 17'h0);

      // stage 0 walk
      for (int i = 1; i <= 6; i++) begin
         p   = 3'(i);
         ci8 = p[2];
         x8  = {7'h0, p[1]};
         y8  = {7'h0, p[0]};
         tick();
         chk($sformatf("st0_%0d", i), {8'h0, c8, s8},
             {9'h0, exp0[i-1]});
      end
      ci8 = 1'b0;

      // per-stage carry-in walk, stage j-1 generates the carry-in
      for (int j = 1; j < 8; j++) begin
         for (int i = 1; i <= 6; i++) begin
            p  = 3'(i);
            x8 = '0;
            y8 = '0;
            y8[j-1] = 1'b1;
            x8[j-1] = p[2];
            x8[j]   = p[1];
            y8[j]   = p[0];
            cnt = int'(p[0]) + int'(p[1]) + int'(p[2]);
            e = '0;
            e[j-1] = ~p[2];
            e[j]   = cnt[0];
            e[j+1] = (cnt >= 2);
            tick();
            chk($sformatf("stg%0d_p%0d", j, i), {8'h0, c8, s8}, e);
         end
      end

      // full ripple and wrap-around
      x8 = 8'hFF; y8 = 8'h00; ci8 = 1'b1;
      tick();
      chk("ripFF00", {8'h0, c8, s8}, 17'h100);
      x8 = 8'hFF; y8 = 8'hFF; ci8 = 1'b1;
      tick();
      chk("ripFFFF", {8'h0, c8, s8}, 17'h1FF);

      // mid-stream reset pulse
      x8 = 8'h7F; y8 = 8'h01; ci8 = 1'b0;
      tick();
      chk("mid_pre", {8'h0, c8, s8}, 17'h080);
      rst = 1'b1;
      tick();
      chk("mid_rst", {8'h0, c8, s8}, 17'h000);
      rst = 1'b0;
      tick();
      chk("mid_post", {8'h0, c8, s8}, 17'h080);

      // random operands on all three widths
      for (int i = 0; i < 300; i++) begin
         logic [16:0] e8, e1, e16;
         x8   = 8'($urandom);
         y8   = 8'($urandom);
         ci8  = 1'($urandom);
         x1   = 1'($urandom);
         y1   = 1'($urandom);
         ci1  = 1'($urandom);
         x16  = 16'($urandom);
         y16  = 16'($urandom);
         ci16 = 1'($urandom);
         e8   = 17'(x8) + 17'(y8) + 17'(ci8);
         e1   = 17'(x1) + 17'(y1) + 17'(ci1);
         e16  = 17'(x16) + 17'(y16) + 17'(ci16);
         tick();
         chk($sformatf("rnd8_%0d", i), {8'h0, c8, s8}, e8);
         chk($sformatf("rnd1_%0d", i), {15'h0, c1, s1}, e1);
         chk($sformatf("rnd16_%0d", i), {c16, s16}, e16);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
